// File: rtl/uartb_rx_fifo.sv
// rtl/uartb_rx_fifo.sv - UART B receiver: 8N1 deserialiser (optional parity) feeding a FWFT receive FIFO
//
// Optional feature macro: UARTB_PARITY_EN (adds PAR state, PARITY_ODD parameter, live perr)
//
// Ports:
//   clk       system clock
//   reset     synchronous active-high reset
//   rxd       asynchronous serial input, idle high
//   rd        pop strobe; head byte consumed at this clk edge
//   clr_err   clears sticky ovf/ferr/perr
//   dout      FIFO head byte (first-word fall-through), 0x00 when empty
//   rx_avail  FIFO not empty
//   rx_full   FIFO holds FIFO_DEPTH bytes
//   ovf       sticky overrun flag
//   ferr      sticky framing-error flag
//   perr      sticky parity-error flag (0 without UARTB_PARITY_EN)
//   irq       registered rx_avail | ovf | ferr | perr

module uartb_rx_fifo #(
    parameter int DIVIDER    = 434,
    parameter int FIFO_DEPTH = 4
`ifdef UARTB_PARITY_EN
    ,
    parameter int PARITY_ODD = 0
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxd,
    input  logic       rd,
    input  logic       clr_err,
    output logic [7:0] dout,
    output logic       rx_avail,
    output logic       rx_full,
    output logic       ovf,
    output logic       ferr,
    output logic       perr,
    output logic       irq
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [15:0] BIT_LOAD  = 16'(DIVIDER - 1);
    localparam logic [15:0] HALF_LOAD = 16'(DIVIDER / 2);
    localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
`ifdef UARTB_PARITY_EN
        PAR   = 3'd3,
`endif
        STOP  = 3'd4
    } state_t;

    state_t      state;
    logic        rx_meta;
    logic        rxs;
    logic [15:0] timer;
    logic [2:0]  bit_idx;
    logic [7:0]  shreg;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic expired;
    logic push;
    logic pop;
    logic wr_en;
    logic ovf_set;
    logic ferr_set;
    logic perr_set;

    // Two-flop synchroniser; flops reset to the idle-high line level so a
    // low line after reset looks like a fresh falling edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rxd;
            rxs     <= rx_meta;
        end
    end

    assign expired = (timer == 16'd0);

`ifdef UARTB_PARITY_EN
    logic par_bad;
    // Even parity: parity bit equals XOR of data; odd parity inverts it.
    logic par_exp;
    assign par_exp = (^shreg) ^ (PARITY_ODD != 0);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            timer   <= 16'd0;
            bit_idx <= 3'd0;
            shreg   <= 8'd0;
`ifdef UARTB_PARITY_EN
            par_bad <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (!rxs) begin
                        timer <= HALF_LOAD;
                        state <= START;
                    end
                end
                START: begin
                    if (expired) begin
                        if (rxs) begin
                            state <= IDLE;
                        end else begin
                            timer   <= BIT_LOAD;
                            bit_idx <= 3'd0;
                            state   <= DATA;
                        end
                    end else begin
                        timer <= timer - 16'd1;
                    end
                end
                DATA: begin
                    if (expired) begin
                        shreg   <= {rxs, shreg[7:1]};
                        timer   <= BIT_LOAD;
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
`ifdef UARTB_PARITY_EN
                            state <= PAR;
`else
                            state <= STOP;
`endif
                        end
                    end else begin
                        timer <= timer - 16'd1;
                    end
                end
`ifdef UARTB_PARITY_EN
                PAR: begin
                    if (expired) begin
                        par_bad <= (rxs != par_exp);
                        timer   <= BIT_LOAD;
                        state   <= STOP;
                    end else begin
                        timer <= timer - 16'd1;
                    end
                end
`endif
                STOP: begin
                    // Straight back to IDLE; a low rxs there starts the next frame.
                    if (expired) begin
                        state <= IDLE;
                    end else begin
                        timer <= timer - 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The byte is pushed on the stop sample regardless of the stop level.
    assign push     = (state == STOP) && expired;
    assign ferr_set = push && !rxs;
`ifdef UARTB_PARITY_EN
    assign perr_set = push && par_bad;
`else
    assign perr_set = 1'b0;
`endif

    assign rx_avail = (count != '0);
    assign rx_full  = (count == FULL_COUNT);
    assign dout     = rx_avail ? mem[rd_ptr] : 8'h00;

    // A pop in the same cycle frees the slot, so a push into a full FIFO
    // with rd is accepted and is not an overrun.
    assign pop     = rd && rx_avail;
    assign wr_en   = push && (!rx_full || pop);
    assign ovf_set = push && rx_full && !pop;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= shreg;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
            ferr   <= 1'b0;
            irq    <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({wr_en, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            // A set event in the same cycle as clr_err keeps the flag set.
            ovf  <= ovf_set  | (ovf  & ~clr_err);
            ferr <= ferr_set | (ferr & ~clr_err);
            irq  <= rx_avail | ovf | ferr | perr;
        end
    end

`ifdef UARTB_PARITY_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perr <= 1'b0;
        end else begin
            perr <= perr_set | (perr & ~clr_err);
        end
    end
`else
    assign perr = perr_set;
`endif

endmodule

// File: tb/tb_uartb_rx_fifo.sv
// tb/tb_uartb_rx_fifo.sv - directed self-checking bench for uartb_rx_fifo

module tb_uartb_rx_fifo;

    localparam int DIV   = 16;
    localparam int DEPTH = 4;
`ifdef UARTB_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    // Edge index (from the start-bit drive) at which the stop bit is sampled.
    localparam int PUSH_EDGE = 4 + DIV / 2 + DIV * (NBITS - 1);

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rxd = 1'b1;
    logic       rd = 1'b0;
    logic       clr_err = 1'b0;
    logic [7:0] dout;
    logic       rx_avail;
    logic       rx_full;
    logic       ovf;
    logic       ferr;
    logic       perr;
    logic       irq;

    int tests = 0;
    int fails = 0;

    uartb_rx_fifo #(.DIVIDER(DIV), .FIFO_DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .rxd      (rxd),
        .rd       (rd),
        .clr_err  (clr_err),
        .dout     (dout),
        .rx_avail (rx_avail),
        .rx_full  (rx_full),
        .ovf      (ovf),
        .ferr     (ferr),
        .perr     (perr),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pop_one();
        rd = 1'b1;
        @(posedge clk);
        #1;
        rd = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        @(posedge clk);
        #1;
        clr_err = 1'b0;
    endtask

    // Called #1 after a posedge; returns #1 after the end of the stop bit.
    task automatic send_frame(input logic [7:0] data, input logic par, input logic stop,
                              input logic rd_at_push, input logic clr_at_push);
        fork
            begin
                rxd = 1'b0;
                repeat (DIV) @(posedge clk);
                #1;
                for (int i = 0; i < 8; i++) begin
                    rxd = data[i];
                    repeat (DIV) @(posedge clk);
                    #1;
                end
`ifdef UARTB_PARITY_EN
                rxd = par;
                repeat (DIV) @(posedge clk);
                #1;
`endif
                rxd = stop;
                repeat (DIV) @(posedge clk);
                #1;
                rxd = 1'b1;
            end
            begin
                repeat (PUSH_EDGE - 1) @(posedge clk);
                #1;
                rd      = rd_at_push;
                clr_err = clr_at_push;
                @(posedge clk);
                #1;
                rd      = 1'b0;
                clr_err = 1'b0;
            end
        join
    endtask

    task automatic test_reset();
        reset = 1'b1;
        rxd = 1'b1;
        idle(3);
        tests++;
        if ({dout, rx_avail, rx_full, ovf, ferr, perr, irq} !== 14'd0) begin
            fails++;
            $display("FAIL reset_hold: got %h want 0", {dout, rx_avail, rx_full, ovf, ferr, perr, irq});
        end
        reset = 1'b0;
        idle(200);
        tests++;
        if ({dout, rx_avail, rx_full, ovf, ferr, perr, irq} !== 14'd0) begin
            fails++;
            $display("FAIL reset_idle: got %h want 0", {dout, rx_avail, rx_full, ovf, ferr, perr, irq});
        end
    endtask

    task automatic test_single();
        send_frame(8'hA5, 1'b0, 1'b1, 1'b0, 1'b0);
        tests++;
        if (rx_avail !== 1'b1) begin fails++; $display("FAIL single_avail: got %b want 1", rx_avail); end
        tests++;
        if (dout !== 8'hA5) begin fails++; $display("FAIL single_dout: got %h want a5", dout); end
        tests++;
        if (irq !== 1'b1) begin fails++; $display("FAIL single_irq: got %b want 1", irq); end
        tests++;
        if (ferr !== 1'b0) begin fails++; $display("FAIL single_ferr: got %b want 0", ferr); end
        pop_one();
        tests++;
        if (rx_avail !== 1'b0) begin fails++; $display("FAIL pop_avail: got %b want 0", rx_avail); end
        tests++;
        if (dout !== 8'h00) begin fails++; $display("FAIL pop_dout: got %h want 00", dout); end
        idle(1);
        tests++;
        if (irq !== 1'b0) begin fails++; $display("FAIL pop_irq: got %b want 0", irq); end
        pop_one();
        tests++;
        if ({rx_avail, dout} !== 9'd0) begin fails++; $display("FAIL rd_empty: got %h want 0", {rx_avail, dout}); end
    endtask

    task automatic test_false_start();
        rxd = 1'b0;
        idle(4);
        rxd = 1'b1;
        idle(40);
        tests++;
        if ({rx_avail, ovf, ferr, perr, irq} !== 5'd0) begin
            fails++;
            $display("FAIL false_start: got %b want 00000", {rx_avail, ovf, ferr, perr, irq});
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b0, 1'b1, 1'b0, 1'b0);
        tests++;
        if ({rx_full, ovf} !== 2'b10) begin fails++; $display("FAIL full4: got %b want 10", {rx_full, ovf}); end
        send_frame(8'h05, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(1);
        tests++;
        if ({rx_full, ovf, irq} !== 3'b111) begin fails++; $display("FAIL overrun: got %b want 111", {rx_full, ovf, irq}); end
        for (int i = 1; i <= 4; i++) begin
            tests++;
            if (dout !== 8'(i)) begin fails++; $display("FAIL ovf_pop%0d: got %h want %h", i, dout, 8'(i)); end
            pop_one();
        end
        tests++;
        if (rx_avail !== 1'b0) begin fails++; $display("FAIL ovf_lost: got %b want 0", rx_avail); end
        pulse_clr();
        tests++;
        if (ovf !== 1'b0) begin fails++; $display("FAIL ovf_clr: got %b want 0", ovf); end

        // Full FIFO, push and rd together: both happen, no overrun.
        for (int i = 0; i < 4; i++) send_frame(8'h11 + 8'(i), 1'b0, 1'b1, 1'b0, 1'b0);
        send_frame(8'h15, 1'b0, 1'b1, 1'b1, 1'b0);
        tests++;
        if ({rx_full, ovf} !== 2'b10) begin fails++; $display("FAIL full_push_rd: got %b want 10", {rx_full, ovf}); end
        for (int i = 2; i <= 5; i++) begin
            tests++;
            if (dout !== 8'h10 + 8'(i)) begin fails++; $display("FAIL full_rd_pop: got %h want %h", dout, 8'h10 + 8'(i)); end
            pop_one();
        end

        // Empty FIFO, push and rd together: rd ignored, push lands.
        send_frame(8'h66, 1'b0, 1'b1, 1'b1, 1'b0);
        tests++;
        if ({rx_avail, dout} !== 9'h166) begin fails++; $display("FAIL empty_push_rd: got %h want 166", {rx_avail, dout}); end
        pop_one();
    endtask

    task automatic test_framing();
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(30);
        tests++;
        if ({rx_avail, dout, ferr} !== 10'b1_0011_1100_1) begin
            fails++;
            $display("FAIL ferr_push: got %b want 1001111001", {rx_avail, dout, ferr});
        end
        pop_one();
        pulse_clr();
        tests++;
        if (ferr !== 1'b0) begin fails++; $display("FAIL ferr_clr: got %b want 0", ferr); end
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(30);
        tests++;
        if ({ferr, dout} !== 9'h15A) begin fails++; $display("FAIL ferr_vs_clr: got %h want 15a", {ferr, dout}); end
        pop_one();
        pulse_clr();
    endtask

`ifdef UARTB_PARITY_EN
    task automatic test_parity();
        send_frame(8'h07, 1'b0, 1'b1, 1'b0, 1'b0);
        tests++;
        if ({perr, dout} !== 9'h107) begin fails++; $display("FAIL perr_bad: got %h want 107", {perr, dout}); end
        pop_one();
        pulse_clr();
        tests++;
        if (perr !== 1'b0) begin fails++; $display("FAIL perr_clr: got %b want 0", perr); end
        send_frame(8'h07, 1'b1, 1'b1, 1'b0, 1'b0);
        tests++;
        if ({perr, ferr, dout} !== 10'h007) begin fails++; $display("FAIL perr_good: got %h want 007", {perr, ferr, dout}); end
        pop_one();
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_false_start();
        test_back_to_back();
        test_framing();
`ifdef UARTB_PARITY_EN
        test_parity();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
